// File: rtl/mole_game_ctrl.sv
// Game sequencer for whack-a-mole: owns score, per-level countdown and level index,
// and steps through play, pause, level-up and win/lose with restart.
module mole_game_ctrl #(
  parameter int SCORE_W     = 8,
  parameter int TIME_W      = 8,
  parameter int LEVEL_W     = 2,
  parameter int NUM_LEVELS  = 3,
  parameter int TARGET_BASE = 10,
  parameter int TARGET_STEP = 5,
  parameter int TIME_LIMIT  = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               hit,
  input  logic               tick,
  output logic [2:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [TIME_W-1:0]  time_left,
  output logic [LEVEL_W-1:0] level,
  output logic               mole_en,
  output logic               win_p,
  output logic               lose_p
);

  // Inputs are single-cycle qualifiers sampled on the rising edge; there is no
  // backpressure, so each pulse is consumed on the cycle it is seen or dropped.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_PAUSE = 3'd2,
    S_LVLUP = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5
  } state_t;

  localparam logic [TIME_W-1:0]  FULL_TIME  = TIME_W'(TIME_LIMIT);
  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);

  state_t             st;
  logic [SCORE_W-1:0] target;
  logic [SCORE_W-1:0] score_inc;
  logic               win_hit;
  logic               time_out;
  logic               last_level;

  assign state = st;

  always_comb begin
    target     = SCORE_W'(TARGET_BASE) + SCORE_W'(level) * SCORE_W'(TARGET_STEP);
    score_inc  = score + SCORE_W'(1);
    win_hit    = hit && (score_inc == target);
    time_out   = tick && (time_left == TIME_W'(1));
    last_level = (level == LAST_LEVEL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_IDLE;
      score     <= '0;
      time_left <= '0;
      level     <= '0;
      mole_en   <= 1'b0;
      win_p     <= 1'b0;
      lose_p    <= 1'b0;
    end else begin
      win_p  <= 1'b0;
      lose_p <= 1'b0;
      case (st)
        S_IDLE, S_WIN, S_LOSE: begin
          // Results hold their final counters for display until a restart.
          if (start) begin
            st        <= S_PLAY;
            score     <= '0;
            level     <= '0;
            time_left <= FULL_TIME;
            mole_en   <= 1'b1;
          end
        end

        S_PLAY: begin
          // Win check outranks timeout, which outranks pause.
          if (win_hit) begin
            score   <= score_inc;
            mole_en <= 1'b0;
            if (last_level) begin
              st    <= S_WIN;
              win_p <= 1'b1;
            end else begin
              st <= S_LVLUP;
            end
          end else if (time_out) begin
            time_left <= '0;
            st        <= S_LOSE;
            lose_p    <= 1'b1;
            mole_en   <= 1'b0;
          end else if (pause) begin
            st      <= S_PAUSE;
            mole_en <= 1'b0;
          end else begin
            if (hit && (score != target))
              score <= score_inc;
            if (tick && (time_left != '0))
              time_left <= time_left - TIME_W'(1);
          end
        end

        S_PAUSE: begin
          if (!pause) begin
            st      <= S_PLAY;
            mole_en <= 1'b1;
          end
        end

        S_LVLUP: begin
          st        <= S_PLAY;
          level     <= level + LEVEL_W'(1);
          score     <= '0;
          time_left <= FULL_TIME;
          mole_en   <= 1'b1;
        end

        default: begin
          st        <= S_IDLE;
          score     <= '0;
          time_left <= '0;
          level     <= '0;
          mole_en   <= 1'b0;
        end
      endcase
    end
  end

endmodule
